// File: rtl/intr_ctrl_if.sv
// rtl/intr_ctrl_if.sv - core-side signal bundle of the interrupt front end
// The core/CSR side drives through master; intr_ctrl sits on slave.
interface intr_ctrl_if #(
  parameter int NUM_SRC = 4
);
  localparam int CW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [NUM_SRC-1:0] irq_in;
  logic               csr_mie;
  logic               csr_mstatus;
  logic               pipe_drained;
  logic               mret_in;
  logic               flush_req;
  logic               int_taken;
  logic               int_ret;
  logic [CW-1:0]      int_cause;
  logic [NUM_SRC-1:0] int_pending;

  modport master (
    output irq_in, csr_mie, csr_mstatus, pipe_drained, mret_in,
    input  flush_req, int_taken, int_ret, int_cause, int_pending
  );

  modport slave (
    input  irq_in, csr_mie, csr_mstatus, pipe_drained, mret_in,
    output flush_req, int_taken, int_ret, int_cause, int_pending
  );
endinterface

// File: rtl/intr_ctrl.sv
// rtl/intr_ctrl.sv - OTTER interrupt front end: sync/edge detect, pending latch, drain/take/return FSM
// All outputs are registered; nothing combinational reaches the CSR unit.
module intr_ctrl #(
  parameter int NUM_SRC     = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  intr_ctrl_if.slave   bus
);
  localparam int CW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  typedef enum logic [1:0] {IDLE, DRAIN, TAKE, HANDLER} state_t;

  state_t             state_q;
  logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];
  logic [NUM_SRC-1:0] prev_q;
  logic [NUM_SRC-1:0] pend_q;
  logic [NUM_SRC-1:0] edge_det;
  logic [NUM_SRC-1:0] clr_mask;
  logic [CW-1:0]      lowest;
  logic [CW-1:0]      cause_q;
  logic               flush_q;
  logic               taken_q;
  logic               ret_q;
  logic               en;

  assign en       = bus.csr_mie & bus.csr_mstatus;
  assign edge_det = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign clr_mask = (state_q == TAKE) ? (NUM_SRC'(1) << cause_q) : '0;

  always_comb begin
    lowest = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (pend_q[i]) lowest = CW'(i);
    end
  end

  // prev resets to 0, so a line already high at reset release reads as an edge
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q <= '0;
      pend_q <= '0;
    end else begin
      sync_q[0] <= bus.irq_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_q[SYNC_STAGES-1];
      pend_q <= (pend_q & ~clr_mask) | edge_det;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      flush_q <= 1'b0;
      taken_q <= 1'b0;
      ret_q   <= 1'b0;
      cause_q <= '0;
    end else begin
      taken_q <= 1'b0;
      ret_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          flush_q <= 1'b0;
          if (en && (|pend_q)) begin
            state_q <= DRAIN;
            flush_q <= 1'b1;
          end
        end
        DRAIN: begin
          if (!en) begin
            state_q <= IDLE;
            flush_q <= 1'b0;
          end else if (bus.pipe_drained) begin
            state_q <= TAKE;
            taken_q <= 1'b1;
            cause_q <= lowest;
          end
        end
        TAKE: begin
          state_q <= HANDLER;
          flush_q <= 1'b0;
        end
        HANDLER: begin
          if (bus.mret_in) begin
            state_q <= IDLE;
            ret_q   <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          flush_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.flush_req   = flush_q;
  assign bus.int_taken   = taken_q;
  assign bus.int_ret     = ret_q;
  assign bus.int_cause   = cause_q;
  assign bus.int_pending = pend_q;
endmodule

// File: tb/tb_intr_ctrl.sv
// tb/tb_intr_ctrl.sv - directed and randomized bench for intr_ctrl against a line-history reference model
module tb_intr_ctrl;
  localparam int NS = 4;
  localparam int SS = 2;
  localparam int P_IDLE = 0, P_DRAIN = 1, P_TAKE = 2, P_HANDLER = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  intr_ctrl_if #(.NUM_SRC(NS)) bus ();
  intr_ctrl #(.NUM_SRC(NS), .SYNC_STAGES(SS)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_vec = 0;
  int n_err = 0;

  // Reference: m_hist[k] is the line value sampled k+1 edges ago
  logic [NS-1:0] m_hist [0:SS];
  logic [NS-1:0] m_pend;
  logic [1:0]    m_cause;
  logic          m_ret;
  int            m_ph;

  always @(posedge clk) begin
    logic [NS-1:0] rise, nxt;
    if (rst) begin
      m_ph = P_IDLE; m_pend = '0; m_cause = '0; m_ret = 1'b0;
      for (int k = 0; k <= SS; k++) m_hist[k] = '0;
    end else begin
      rise = m_hist[SS-1] & ~m_hist[SS];
      nxt = m_pend;
      if (m_ph == P_TAKE) nxt[m_cause] = 1'b0;
      nxt = nxt | rise;
      m_ret = 1'b0;
      case (m_ph)
        P_IDLE:  if (bus.csr_mie && bus.csr_mstatus && m_pend != 0) m_ph = P_DRAIN;
        P_DRAIN: begin
          if (!(bus.csr_mie && bus.csr_mstatus)) m_ph = P_IDLE;
          else if (bus.pipe_drained) begin
            m_ph = P_TAKE;
            for (int i = NS - 1; i >= 0; i--) if (m_pend[i]) m_cause = 2'(i);
          end
        end
        P_TAKE:  m_ph = P_HANDLER;
        default: if (bus.mret_in) begin m_ph = P_IDLE; m_ret = 1'b1; end
      endcase
      m_pend = nxt;
      for (int k = SS; k >= 1; k--) m_hist[k] = m_hist[k-1];
      m_hist[0] = bus.irq_in;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    check("m_flush", 32'(bus.flush_req), 32'(m_ph == P_DRAIN || m_ph == P_TAKE));
    check("m_taken", 32'(bus.int_taken), 32'(m_ph == P_TAKE));
    check("m_ret", 32'(bus.int_ret), 32'(m_ret));
    check("m_cause", 32'(bus.int_cause), 32'(m_cause));
    check("m_pend", 32'(bus.int_pending), 32'(m_pend));
  endtask

  task automatic wait_taken(input int budget);
    int n = 0;
    while (bus.int_taken !== 1'b1 && n < budget) begin tick(); n++; end
    check("wait_taken", 32'(bus.int_taken), 32'd1);
  endtask

  task automatic wait_flush(input int budget);
    int n = 0;
    while (bus.flush_req !== 1'b1 && n < budget) begin tick(); n++; end
    check("wait_flush", 32'(bus.flush_req), 32'd1);
  endtask

  task automatic pulse_mret();
    bus.mret_in = 1'b1;
    tick();
    bus.mret_in = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.irq_in = '0; bus.csr_mie = 1'b0; bus.csr_mstatus = 1'b0;
    bus.pipe_drained = 1'b0; bus.mret_in = 1'b0;
    tick(); tick();
    check("rst_flush", 32'(bus.flush_req), 32'd0);
    check("rst_taken", 32'(bus.int_taken), 32'd0);
    check("rst_pend", 32'(bus.int_pending), 32'd0);
    rst = 1'b0;
    bus.csr_mie = 1'b1; bus.csr_mstatus = 1'b1; bus.pipe_drained = 1'b1;
    repeat (3) tick();

    // single source latency: irq[2] rises before edge 0
    bus.irq_in = 4'b0100;
    tick();
    tick();
    check("t1_pend_e1", 32'(bus.int_pending), 32'h0);
    tick();
    check("t1_pend_e2", 32'(bus.int_pending), 32'h4);
    tick();
    check("t1_flush_e3", 32'(bus.flush_req), 32'd1);
    check("t1_taken_e3", 32'(bus.int_taken), 32'd0);
    tick();
    check("t1_taken_e4", 32'(bus.int_taken), 32'd1);
    check("t1_cause_e4", 32'(bus.int_cause), 32'd2);
    tick();
    check("t1_pend_e5", 32'(bus.int_pending), 32'h0);
    check("t1_flush_e5", 32'(bus.flush_req), 32'd0);
    pulse_mret();
    check("t4_ret", 32'(bus.int_ret), 32'd1);
    tick();
    check("t4_ret_once", 32'(bus.int_ret), 32'd0);
    bus.irq_in = '0;

    // simultaneous sources: lowest index first
    bus.irq_in = 4'b1010;
    wait_taken(20);
    check("t2_cause_a", 32'(bus.int_cause), 32'd1);
    tick();
    pulse_mret();
    wait_taken(20);
    check("t2_cause_b", 32'(bus.int_cause), 32'd3);
    tick();
    pulse_mret();
    tick();
    bus.irq_in = '0;
    repeat (2) tick();
    pulse_mret();
    check("t4_idle_mret", 32'(bus.int_ret), 32'd0);
    tick();
    check("t4_idle_mret2", 32'(bus.int_ret), 32'd0);

    // drain abandoned when enable drops
    bus.pipe_drained = 1'b0;
    bus.irq_in = 4'b0001;
    wait_flush(20);
    repeat (5) begin
      tick();
      check("t3_no_take", 32'(bus.int_taken), 32'd0);
    end
    bus.csr_mstatus = 1'b0;
    tick();
    check("t3_flush_drop", 32'(bus.flush_req), 32'd0);
    check("t3_no_take2", 32'(bus.int_taken), 32'd0);
    check("t3_pend_kept", 32'(bus.int_pending[0]), 32'd1);
    bus.csr_mstatus = 1'b1; bus.pipe_drained = 1'b1;
    wait_taken(20);
    check("t3_cause", 32'(bus.int_cause), 32'd0);
    bus.irq_in = '0;
    tick();
    pulse_mret();
    repeat (4) tick();

    // new edge on source 0 lands in its own TAKE cycle
    bus.irq_in = 4'b0001;
    tick();
    bus.irq_in = 4'b0000;
    tick(); tick();
    bus.irq_in = 4'b0001;
    tick(); tick();
    check("t5_taken", 32'(bus.int_taken), 32'd1);
    check("t5_cause", 32'(bus.int_cause), 32'd0);
    tick();
    check("t5_pend_kept", 32'(bus.int_pending[0]), 32'd1);

    // reset during DRAIN, then during TAKE
    bus.pipe_drained = 1'b0;
    pulse_mret();
    wait_flush(20);
    rst = 1'b1;
    tick();
    check("t6_drain_flush", 32'(bus.flush_req), 32'd0);
    check("t6_drain_taken", 32'(bus.int_taken), 32'd0);
    check("t6_drain_pend", 32'(bus.int_pending), 32'd0);
    rst = 1'b0;
    bus.pipe_drained = 1'b1;
    wait_taken(20);
    rst = 1'b1;
    bus.irq_in = '0;
    tick();
    check("t6_take_taken", 32'(bus.int_taken), 32'd0);
    check("t6_take_flush", 32'(bus.flush_req), 32'd0);
    check("t6_take_ret", 32'(bus.int_ret), 32'd0);
    check("t6_take_cause", 32'(bus.int_cause), 32'd0);
    rst = 1'b0;
    repeat (3) tick();

    // randomized traffic against the reference model
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) bus.irq_in = bus.irq_in ^ 4'($urandom);
      bus.csr_mie      = ($urandom_range(0, 9) != 0);
      bus.csr_mstatus  = ($urandom_range(0, 7) != 0);
      bus.pipe_drained = ($urandom_range(0, 2) != 0);
      bus.mret_in      = ($urandom_range(0, 3) == 0);
      rst              = ($urandom_range(0, 80) == 0);
      tick();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
